// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  // Bundle widths of the ID/EX boundary, used when instantiating that stage.
  localparam int ID_EX_CTRL_W = 12;
  localparam int ID_EX_DATA_W = 213;

  // Number of instructions a flush kills: held main, held skid, and one accepted in the same cycle.
  function automatic logic [1:0] kill_incr(input logic main_v, input logic skid_v, input logic acc);
    return {1'b0, main_v} + {1'b0, skid_v} + {1'b0, acc};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle; it never wraps.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W+1:0] sum_w;

  // Add in a wider word and clamp to all-ones if the sum spills past CNT_W bits.
  always_comb begin
    sum_w   = {2'b00, count_q} + {{CNT_W{1'b0}}, inc};
    count_d = sum_w[CNT_W-1:0];
    if (sum_w[CNT_W+1:CNT_W] != 2'b00) begin
      count_d = '1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional two-entry skid
// buffer, synchronous flush that inserts bubbles, and a flush-kill counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = ID_EX_CTRL_W,
  parameter int DATA_W   = ID_EX_DATA_W,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  kill_cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              emit;
  logic [1:0]        kill_inc;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == pipe_pkg::SKID);

  // With the skid buffer in_ready is a pure register; without it, the stage
  // can take a new instruction whenever its single entry is free or leaving.
  assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);

  assign accept = in_valid && in_ready;
  assign emit   = main_valid && out_ready;

  // Next-state and entry updates; flush overrides every transfer and empties the stage.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (accept && emit) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end else if (accept && (SKID != 0)) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = pipe_pkg::SKID;
          end
        end
        pipe_pkg::SKID: begin
          if (emit) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != pipe_pkg::SKID);
  end

  // State, entry and registered-ready flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Kill count only moves on a flush edge.
  always_comb begin
    kill_inc = 2'd0;
    if (flush) begin
      kill_inc = kill_incr(main_valid, skid_valid, accept);
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_kill_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (kill_inc),
    .count(kill_cnt)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the RISC-V core: the generalised successor of the fixed-field ID/EX register.
- Carries a control bundle (CTRL_W) and a data bundle (DATA_W) between any two stages.
- Uses a valid/ready handshake, an optional 2-entry skid buffer for full-throughput stalls, and a synchronous flush that inserts bubbles.
- Counts flush-killed instructions for performance monitoring.

Parameters:
- CTRL_W, 12, width of control bundle (RegWrite, ResultSrc, MemWrite, Branch, ALUControl, ...); forced to 0 in bubbles.
- DATA_W, 213, width of data bundle (operands, PC, imm, instr, register indices).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CLR_DATA, 0, 1 = data bundle also zeroed on flush; 0 = data held.
- CNT_W, 16, width of flush-kill counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle.
- flush  in  1  synchronous kill of all held and incoming instructions.
- kill_cnt  out  CNT_W  saturating count of instructions killed by flush.

Behaviour:
- Reset (rst=1, async): both entries invalid, all ctrl/data registers 0, out_valid=0, out_ctrl=0, out_data=0, kill_cnt=0, state EMPTY. in_ready=1 on the first cycle after reset release.
- Transfers: accept = in_valid && in_ready; emit = out_valid && out_ready. Both are evaluated at the rising edge.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 per cycle with out_ready held at 1.
- SKID=1, state EMPTY (no entry valid):
  - accept: load main, go to FULL.
- SKID=1, state FULL (main valid):
  - accept and emit: main is replaced by the input; stay FULL.
  - emit only: go to EMPTY.
  - accept only: load skid, go to SKID.
  - neither: hold.
- SKID=1, state SKID (main and skid valid):
  - in_ready=0.
  - emit: main <= skid, go to FULL.
  - no emit: hold.
- SKID=1, in_ready: in_ready = (state != SKID). It is a register output only; no combinational path from out_ready.
- SKID=0:
  - States are EMPTY and FULL only.
  - in_ready = !out_valid || out_ready (combinational).
  - Otherwise the same transitions as SKID=1 without the SKID state.
- Ordering: out_ctrl/out_data always present main. The skid entry never overtakes main.
- Flush (highest priority):
  - In the flush cycle the registers take no accept and no emit update. Next state is EMPTY. Both entries' valid and ctrl go to 0.
  - Data goes to 0 if CLR_DATA=1, else it is held.
  - An input offered in the same cycle is dropped, even if in_ready=1 (it is counted as killed only if the accept condition held).
  - Outputs during the flush cycle still show the pre-flush state. Downstream must gate with flush externally.
- Flush with out_valid=0 and no accept: kill_cnt is unchanged.
- kill_cnt update: kill_cnt += (main valid) + (skid valid) + (accept) on each flush edge, saturating at 2^CNT_W-1 with no wrap.
- Back-to-back flushes: each flush cycle is independent; EMPTY is held.
- Reset mid-operation: immediate return to reset values, no dependence on clk.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef pipe_state_e {EMPTY, FULL, SKID};
  - the per-stage CTRL_W/DATA_W constants (ID_EX_CTRL_W=12, ID_EX_DATA_W=213) for instantiation.
- One natural sub-module: sat_counter (CNT_W, increment 0..3, saturate), used for kill_cnt.

Test Plan:
- Reset: assert rst mid-stream with 2 entries valid -> out_valid=0, out_ctrl=0, kill_cnt=0 with no clock edge; in_ready=1 after release.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 0x01..0x08 -> out_data 0x01..0x08 appear one cycle after acceptance, one per cycle, in_ready stays 1.
- Stall and skid (SKID=1): stream 0xA,0xB,0xC and drop out_ready after 0xA appears -> 0xB goes to skid, in_ready=0 next cycle, 0xC is held upstream. Raise out_ready -> output order 0xA,0xB,0xC with no loss or duplication.
- Flush in SKID state with in_valid=1 and in_ready=0:
  - Next cycle: out_valid=0, out_ctrl=0, kill_cnt += 2.
  - CLR_DATA=1: out_data=0. CLR_DATA=0: out_data unchanged.
- Flush in FULL state with accept: kill_cnt += 2; following cycle in_ready=1 and EMPTY.
- Saturation (CNT_W=2): 3 flushes each killing 2 -> kill_cnt=3, never wraps.
- SKID=0 variant: out_ready=0 with FULL -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 in the same cycle, with simultaneous accept and emit.
